csr_access_unit: RTL and testbench

Sequencer between the decode/execute stage and the machine-mode CSR register file. It accepts one decoded Zicsr instruction at a time over a valid/ready handshake and reads the old CSR value. It then issues at most one write/set/clear access and returns the old value for rd writeback over a second valid/ready handshake. It is the only driver of the register file's `number`, `access_type` and `in` inputs.

---
 rtl/csr_access_unit.sv | 109 ++++++++++
 tb/tb_csr_access_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/csr_access_unit.sv
// csr_access_unit: sequences one Zicsr instruction into read, optional write and response phases
// Ports: clk, reset_n (async active-low); req_* accept a decoded CSR instruction (valid/ready);
//   csr_number/csr_access_type/csr_in drive the CSR register file, csr_out is its combinational
//   read data; rsp_* return the old CSR value for rd writeback (valid/ready).
// Build option: define CSR_IMM_EN to support CSRRWI/CSRRSI/CSRRCI; otherwise they are illegal.
module csr_access_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [11:0]     req_csr,
  input  logic [4:0]      req_rs1_idx,
  input  logic [XLEN-1:0] req_rs1_val,
  input  logic [4:0]      req_rd,
  output logic [11:0]     csr_number,
  output logic [1:0]      csr_access_type,
  output logic [XLEN-1:0] csr_in,
  input  logic [XLEN-1:0] csr_out,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [4:0]      rsp_rd,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_we,
  output logic            rsp_illegal
);
  localparam logic [1:0] CSR_READ_ONLY = 2'd0, CSR_WRITE = 2'd1, CSR_SET = 2'd2, CSR_CLEAR = 2'd3;
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t          state;
  logic [1:0]      op;
  logic            bad_op;
  logic [4:0]      idx;
  logic [XLEN-1:0] opnd;
  logic            do_write, illegal, req_bad;
  logic [1:0]      wr_type;
  logic [XLEN-1:0] req_opnd;
  always_comb begin
`ifdef CSR_IMM_EN
    req_bad  = req_funct3[1:0] == 2'b00;
    req_opnd = req_funct3[2] ? {{(XLEN-5){1'b0}}, req_rs1_idx} : req_rs1_val;
`else
    req_bad  = req_funct3[2] || req_funct3[1:0] == 2'b00;
    req_opnd = req_rs1_val;
`endif
    do_write = op == 2'b01 || idx != 5'd0;
    // csr_number still holds the latched address while in READ
    illegal  = bad_op || (do_write && csr_number[11:10] == 2'b11);
    wr_type  = op == 2'b01 ? CSR_WRITE : op == 2'b10 ? CSR_SET : CSR_CLEAR;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      op              <= 2'd0;
      bad_op          <= 1'b0;
      idx             <= 5'd0;
      opnd            <= '0;
      req_ready       <= 1'b1;
      csr_number      <= 12'd0;
      csr_access_type <= CSR_READ_ONLY;
      csr_in          <= '0;
      rsp_valid       <= 1'b0;
      rsp_rd          <= 5'd0;
      rsp_data        <= '0;
      rsp_we          <= 1'b0;
      rsp_illegal     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          state      <= READ;
          req_ready  <= 1'b0;
          csr_number <= req_csr;
          op         <= req_funct3[1:0];
          bad_op     <= req_bad;
          idx        <= req_rs1_idx;
          opnd       <= req_opnd;
          rsp_rd     <= req_rd;
        end
        READ: begin
          rsp_data    <= csr_out;
          rsp_illegal <= illegal;
          rsp_we      <= rsp_rd != 5'd0 && !illegal;
          if (do_write && !illegal) begin
            state           <= WRITE;
            csr_access_type <= wr_type;
            csr_in          <= opnd;
          end else begin
            state      <= RESP;
            csr_number <= 12'd0;
            rsp_valid  <= 1'b1;
          end
        end
        WRITE: begin
          state           <= RESP;
          csr_number      <= 12'd0;
          csr_access_type <= CSR_READ_ONLY;
          csr_in          <= '0;
          rsp_valid       <= 1'b1;
        end
        default: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_csr_access_unit.sv
// tb_csr_access_unit: table-driven scoreboard bench for csr_access_unit with a small CSR file model
module tb_csr_access_unit;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [2:0]  req_funct3 = 3'd0;
  logic [11:0] req_csr = 12'd0;
  logic [4:0]  req_rs1_idx = 5'd0, req_rd = 5'd0;
  logic [31:0] req_rs1_val = 32'd0;
  logic [11:0] csr_number;
  logic [1:0]  csr_access_type;
  logic [31:0] csr_in, csr_out;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [4:0]  rsp_rd;
  logic [31:0] rsp_data;
  logic        rsp_we, rsp_illegal;
  always #5 clk = ~clk;
  csr_access_unit dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_csr(req_csr), .req_rs1_idx(req_rs1_idx),
    .req_rs1_val(req_rs1_val), .req_rd(req_rd), .csr_number(csr_number),
    .csr_access_type(csr_access_type), .csr_in(csr_in), .csr_out(csr_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd), .rsp_data(rsp_data),
    .rsp_we(rsp_we), .rsp_illegal(rsp_illegal)
  );
  // CSR file model: mtvec and mepc writable, misa read-only, everything else reads 0
  logic [31:0] mtvec = 32'd0, mepc = 32'd0;
  int          wr_cnt = 0;
  always_comb csr_out = csr_number == 12'h305 ? mtvec : csr_number == 12'h341 ? mepc :
                        csr_number == 12'h301 ? 32'h4000_0100 : 32'd0;
  function automatic logic [31:0] upd(input logic [1:0] t, input logic [31:0] o, input logic [31:0] v);
    return t == 2'd1 ? v : t == 2'd2 ? (o | v) : (o & ~v);
  endfunction
  always @(posedge clk)
    if (csr_access_type != 2'd0) begin
      wr_cnt <= wr_cnt + 1;
      if (csr_number == 12'h305) mtvec <= upd(csr_access_type, mtvec, csr_in);
      if (csr_number == 12'h341) mepc <= upd(csr_access_type, mepc, csr_in);
    end
  typedef struct {
    logic [2:0]  f3;
    logic [11:0] csr;
    logic [4:0]  idx;
    logic [31:0] val;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        ill;
    logic        we;
    int          lat;
  } vec_t;
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        ill;
    logic        we;
    int          lat;
  } exp_t;
  exp_t q[$];
  int passed = 0, total = 0;
`ifdef CSR_IMM_EN
  localparam logic [31:0] MTVEC_END = 32'h1F;
`else
  localparam logic [31:0] MTVEC_END = 32'h1000;
`endif
  task automatic chk(input string n, input int id, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s #%0d: got %h want %h", n, id, act, exp);
  endtask
  task automatic issue(input vec_t v);
    req_valid   = 1'b1;
    req_funct3  = v.f3;
    req_csr     = v.csr;
    req_rs1_idx = v.idx;
    req_rs1_val = v.val;
    req_rd      = v.rd;
  endtask
  task automatic run(input vec_t v, input int id, input int stall);
    exp_t e;
    int   n, w0;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("req_ready_idle", id, 32'(req_ready), 32'd1);
    issue(v);
    q.push_back('{v.rd, v.data, v.ill, v.we, v.lat});
    w0 = wr_cnt;
    @(negedge clk);
    req_valid = 1'b0;
    chk("req_ready_busy", id, 32'(req_ready), 32'd0);
    n = 1;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    e = q.pop_front();
    chk("latency", id, 32'(n), 32'(e.lat));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", id, 32'(rsp_valid), 32'd1);
      chk("stall_data", id, rsp_data, e.data);
      chk("stall_ready", id, 32'(req_ready), 32'd0);
    end
    chk("rsp_data", id, rsp_data, e.data);
    chk("rsp_rd", id, 32'(rsp_rd), 32'(e.rd));
    chk("rsp_we", id, 32'(rsp_we), 32'(e.we));
    chk("rsp_illegal", id, 32'(rsp_illegal), 32'(e.ill));
    chk("write_count", id, 32'(wr_cnt - w0), e.lat == 3 ? 32'd1 : 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("ready_after", id, 32'(req_ready), 32'd1);
    chk("valid_after", id, 32'(rsp_valid), 32'd0);
    chk("idle_bus", id, {csr_number, 18'd0, csr_access_type}, 32'd0);
    chk("idle_in", id, csr_in, 32'd0);
  endtask
  vec_t t[13];
  initial begin
    t[0]  = '{3'b001, 12'h305, 5'd1, 32'h1000, 5'd5, 32'h0, 1'b0, 1'b1, 3};
    t[1]  = '{3'b010, 12'h305, 5'd0, 32'hFFFF, 5'd6, 32'h1000, 1'b0, 1'b1, 2};
    t[2]  = '{3'b001, 12'h341, 5'd2, 32'h100, 5'd0, 32'h0, 1'b0, 1'b0, 3};
    t[3]  = '{3'b010, 12'h341, 5'd3, 32'hF, 5'd8, 32'h100, 1'b0, 1'b1, 3};
    t[4]  = '{3'b011, 12'h341, 5'd4, 32'h3, 5'd9, 32'h10F, 1'b0, 1'b1, 3};
    t[5]  = '{3'b010, 12'h341, 5'd0, 32'h0, 5'd10, 32'h10C, 1'b0, 1'b1, 2};
    t[6]  = '{3'b010, 12'h301, 5'd0, 32'h0, 5'd7, 32'h4000_0100, 1'b0, 1'b1, 2};
    t[7]  = '{3'b001, 12'hF11, 5'd3, 32'h55, 5'd4, 32'h0, 1'b1, 1'b0, 2};
    t[8]  = '{3'b010, 12'hF11, 5'd0, 32'h0, 5'd4, 32'h0, 1'b0, 1'b1, 2};
    t[9]  = '{3'b000, 12'h305, 5'd2, 32'hFFFF, 5'd3, 32'h1000, 1'b1, 1'b0, 2};
    t[10] = '{3'b100, 12'h305, 5'd2, 32'hFFFF, 5'd3, 32'h1000, 1'b1, 1'b0, 2};
`ifdef CSR_IMM_EN
    t[11] = '{3'b101, 12'h305, 5'h1F, 32'hDEAD, 5'd11, 32'h1000, 1'b0, 1'b1, 3};
`else
    t[11] = '{3'b101, 12'h305, 5'h1F, 32'hDEAD, 5'd11, 32'h1000, 1'b1, 1'b0, 2};
`endif
    t[12] = '{3'b010, 12'h305, 5'd0, 32'h0, 5'd1, MTVEC_END, 1'b0, 1'b1, 2};
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 0, 32'(req_ready), 32'd1);
    chk("rst_rsp", 0, {rsp_data[26:0], rsp_rd}, 32'd0);
    chk("rst_flags", 0, {29'd0, rsp_valid, rsp_we, rsp_illegal}, 32'd0);
    chk("rst_csr_bus", 0, {csr_number, 18'd0, csr_access_type}, 32'd0);
    chk("rst_csr_in", 0, csr_in, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 13; i++) run(t[i], i, i == 3 ? 5 : 0);
    chk("mepc_final", 0, mepc, 32'h10C);
    chk("mtvec_final", 0, mtvec, MTVEC_END);
    // reset asserted while a write is pending
    begin
      int w0;
      w0 = wr_cnt;
      issue('{3'b001, 12'h305, 5'd1, 32'hABCD, 5'd3, 32'h0, 1'b0, 1'b0, 0});
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      #2;
      chk("rst_write_pending", 20, 32'(csr_access_type), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("rst_async_type", 20, 32'(csr_access_type), 32'd0);
      chk("rst_async_ready", 20, 32'(req_ready), 32'd1);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_mtvec", 20, mtvec, MTVEC_END);
      chk("rst_no_write", 20, 32'(wr_cnt - w0), 32'd0);
      chk("rst_rsp_valid", 20, 32'(rsp_valid), 32'd0);
      chk("rst_ready_after", 20, 32'(req_ready), 32'd1);
    end
    run('{3'b010, 12'h305, 5'd0, 32'h0, 5'd2, MTVEC_END, 1'b0, 1'b1, 2}, 21, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
